// File: rtl/game_round_controller_if.sv
// Handshake and status bundle between the round controller and the GUI/detector side.
// slave = controller view, master = GUI/detector view.
interface game_round_controller_if;
    logic       start_game;
    logic [1:0] lvl;
    logic       detect_req;
    logic       color_done;
    logic [7:0] detected_color;
    logic [7:0] question;
    logic       q_valid;
    logic [1:0] result;
    logic       result_valid;
    logic       result_ack;
    logic [3:0] score;
    logic [3:0] round_idx;
    logic       busy;
    logic       game_over;
    logic [2:0] led_state;

    modport master (
        output start_game, lvl, color_done, detected_color, result_ack,
        input  detect_req, question, q_valid, result, result_valid,
               score, round_idx, busy, game_over, led_state
    );

    modport slave (
        input  start_game, lvl, color_done, detected_color, result_ack,
        output detect_req, question, q_valid, result, result_valid,
               score, round_idx, busy, game_over, led_state
    );
endinterface

// File: rtl/game_round_controller.sv
// Round sequencer: LFSR question, detection request, masked compare, held result handshake.
// Define ROUND_TIMEOUT_EN to add the per-round detection timeout (result 11).
module game_round_controller #(
    parameter int unsigned NUM_ROUNDS     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 25_000_000,
    parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
    input  logic                    pclk,
    input  logic                    reset_n,
    game_round_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GEN_Q   = 3'd1,
        DETECT  = 3'd2,
        COMPARE = 3'd3,
        REPORT  = 3'd4,
        NEXT    = 3'd5,
        DONE    = 3'd6
    } state_e;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

    function automatic logic [7:0] slot_mask(input logic [1:0] l);
        case (l)
            2'd0:    return 8'h03;
            2'd1:    return 8'h0F;
            2'd2:    return 8'h3F;
            default: return 8'hFF;
        endcase
    endfunction

    state_e     state_q, state_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [7:0] question_q, question_d;
    logic [7:0] det_q, det_d;
    logic [1:0] lvl_q, lvl_d;
    logic [1:0] result_q, result_d;
    logic [3:0] score_q, score_d;
    logic [3:0] round_q, round_d;
    logic       q_valid_q, q_valid_d;
    logic       detect_req_q, detect_req_d;
    logic       to_hit;
    logic       timed_out;
    logic       match;

    // Only slots 0..lvl take part in the comparison.
    assign match = ((det_q ^ question_q) & slot_mask(lvl_q)) == 8'h00;

`ifdef ROUND_TIMEOUT_EN
    localparam logic [24:0] TO_LAST = 25'(TIMEOUT_CYCLES - 1);

    logic [24:0] cnt_q;
    logic        timeout_q;

    assign to_hit    = (cnt_q == TO_LAST);
    assign timed_out = timeout_q;

    // timeout_q is only set on the DETECT exit cycle, so it stays valid through COMPARE.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else if (state_q == GEN_Q) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else if (state_q == DETECT) begin
            cnt_q     <= cnt_q + 25'd1;
            timeout_q <= !bus.color_done && to_hit;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYCLES;
    assign to_hit     = 1'b0;
    assign timed_out  = 1'b0;
`endif

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (bus.start_game) state_d = GEN_Q;
            GEN_Q:      state_d = DETECT;
            DETECT:     if (bus.color_done || to_hit) state_d = COMPARE;
            COMPARE:    state_d = REPORT;
            REPORT:     if (bus.result_ack) state_d = NEXT;
            NEXT:       state_d = (round_q == LAST_ROUND) ? DONE : GEN_Q;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        lfsr_d       = (lfsr_q >> 1) ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
        question_d   = question_q;
        det_d        = det_q;
        lvl_d        = lvl_q;
        result_d     = result_q;
        score_d      = score_q;
        round_d      = round_q;
        q_valid_d    = q_valid_q;
        detect_req_d = (state_q == GEN_Q);
        case (state_q)
            IDLE, DONE: begin
                if (bus.start_game) begin
                    lvl_d    = bus.lvl;
                    score_d  = '0;
                    round_d  = '0;
                    result_d = '0;
                end
            end
            GEN_Q: begin
                question_d = lfsr_q & slot_mask(lvl_q);
                q_valid_d  = 1'b1;
            end
            DETECT: if (bus.color_done) det_d = bus.detected_color;
            COMPARE: begin
                if (timed_out) begin
                    result_d = 2'b11;
                end else if (match) begin
                    result_d = 2'b01;
                    if (score_q != 4'hF) score_d = score_q + 4'd1;
                end else begin
                    result_d = 2'b10;
                end
            end
            REPORT: if (bus.result_ack) q_valid_d = 1'b0;
            NEXT:   if (round_q != LAST_ROUND) round_d = round_q + 4'd1;
            default: ;
        endcase
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q       <= LFSR_SEED;
            question_q   <= '0;
            det_q        <= '0;
            lvl_q        <= '0;
            result_q     <= '0;
            score_q      <= '0;
            round_q      <= '0;
            q_valid_q    <= 1'b0;
            detect_req_q <= 1'b0;
        end else begin
            lfsr_q       <= lfsr_d;
            question_q   <= question_d;
            det_q        <= det_d;
            lvl_q        <= lvl_d;
            result_q     <= result_d;
            score_q      <= score_d;
            round_q      <= round_d;
            q_valid_q    <= q_valid_d;
            detect_req_q <= detect_req_d;
        end
    end

    always_comb begin
        bus.busy         = (state_q != IDLE) && (state_q != DONE);
        bus.game_over    = (state_q == DONE);
        bus.result_valid = (state_q == REPORT);
        bus.led_state    = state_q;
    end

    assign bus.detect_req = detect_req_q;
    assign bus.question   = question_q;
    assign bus.q_valid    = q_valid_q;
    assign bus.result     = result_q;
    assign bus.score      = score_q;
    assign bus.round_idx  = round_q;

endmodule

// File: tb/tb_game_round_controller.sv
// Randomized bench for game_round_controller with a per-cycle behavioural reference model.
// Timeout scenarios run only when ROUND_TIMEOUT_EN is defined.
module tb_game_round_controller;

    localparam int NR = 2;
    localparam int TO = 16;

    logic pclk;
    logic rst_n;

    game_round_controller_if bus ();

    game_round_controller #(
        .NUM_ROUNDS    (NR),
        .TIMEOUT_CYCLES(TO),
        .LFSR_SEED     (8'hA5)
    ) dut (
        .pclk   (pclk),
        .reset_n(rst_n),
        .bus    (bus)
    );

    int tests = 0;
    int fails = 0;

    // reference model: phase numbers follow the published led_state values
    int         m_phase;
    logic [7:0] m_lfsr, m_q, m_det;
    logic [1:0] m_lvl, m_res;
    int         m_score, m_round, m_cnt;
    logic       m_qv, m_dreq, m_to;

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] keep_slots(input logic [7:0] v, input logic [1:0] l);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < 4; i++)
            if (i > int'(l)) r[2*i +: 2] = 2'b00;
        return r;
    endfunction

    function automatic bit slots_equal(input logic [7:0] a, input logic [7:0] b, input logic [1:0] l);
        for (int i = 0; i <= int'(l); i++)
            if (a[2*i +: 2] != b[2*i +: 2]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_lfsr = 8'hA5; m_q = '0; m_det = '0; m_lvl = '0; m_res = '0;
        m_score = 0; m_round = 0; m_cnt = 0; m_qv = 1'b0; m_dreq = 1'b0; m_to = 1'b0;
    endtask

    task automatic model_step();
        int         ph;
        logic [7:0] lf;
        ph     = m_phase;
        lf     = m_lfsr;
        m_dreq = (ph == 1);
        m_lfsr = {1'b0, lf[7:1]} ^ (lf[0] ? 8'hB8 : 8'h00);
        case (ph)
            0, 6: if (bus.start_game) begin
                m_phase = 1; m_lvl = bus.lvl; m_score = 0; m_round = 0; m_res = 2'b00;
            end
            1: begin
                m_q = keep_slots(lf, m_lvl); m_qv = 1'b1; m_cnt = 0; m_phase = 2;
            end
            2: begin
                if (bus.color_done) begin
                    m_det = bus.detected_color; m_to = 1'b0; m_phase = 3;
                end
`ifdef ROUND_TIMEOUT_EN
                else if (m_cnt == TO - 1) begin
                    m_to = 1'b1; m_phase = 3;
                end
                m_cnt++;
`endif
            end
            3: begin
                if (m_to) m_res = 2'b11;
                else if (slots_equal(m_det, m_q, m_lvl)) begin
                    m_res = 2'b01;
                    if (m_score < 15) m_score++;
                end else m_res = 2'b10;
                m_phase = 4;
            end
            4: if (bus.result_ack) begin
                m_qv = 1'b0; m_phase = 5;
            end
            5: begin
                if (m_round == NR - 1) m_phase = 6;
                else begin m_round++; m_phase = 1; end
            end
            default: ;
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge pclk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // every cycle: all outputs against the model
    initial begin
        forever begin
            @(negedge pclk);
            chk("detect_req",   32'(bus.detect_req),   32'(m_dreq));
            chk("question",     32'(bus.question),     32'(m_q));
            chk("q_valid",      32'(bus.q_valid),      32'(m_qv));
            chk("result",       32'(bus.result),       32'(m_res));
            chk("result_valid", 32'(bus.result_valid), 32'(m_phase == 4));
            chk("score",        32'(bus.score),        32'(m_score));
            chk("round_idx",    32'(bus.round_idx),    32'(m_round));
            chk("busy",         32'(bus.busy),         32'(m_phase >= 1 && m_phase <= 5));
            chk("game_over",    32'(bus.game_over),    32'(m_phase == 6));
            chk("led_state",    32'(bus.led_state),    32'(m_phase));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge pclk);
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!bus.detect_req && n < 40) begin
            tick();
            n++;
        end
    endtask

    function automatic logic [7:0] make_det(input int mode);
        logic [7:0] keep, d;
        int s;
        keep = keep_slots(8'hFF, m_lvl);
        d = (m_q & keep) | (8'($urandom) & ~keep);
        if (mode == 3) d = (m_q & keep) | (~m_q & ~keep);
        if (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1)) begin
            s = $urandom_range(0, int'(m_lvl));
            d[2*s +: 2] = d[2*s +: 2] ^ 2'($urandom_range(1, 3));
        end
        return d;
    endfunction

    task automatic start_game(input logic [1:0] l);
        int n;
        bus.lvl = l;
        bus.start_game = 1'b1;
        tick();
        bus.start_game = 1'b0;
        bus.lvl = 2'($urandom);
        wait_req(n);
        chk("start_to_req", 32'(n + 1), 32'd2);
    endtask

    // mode: 0 match, 1 mismatch, 2 random, 3 match with upper slots inverted
    task automatic play_round(input int mode, input int cd_delay, input int ack_delay,
                              input bit last, output logic [1:0] r);
        int k;
        for (int i = 0; i < cd_delay; i++) begin
            bus.start_game = (i == 0);
            bus.result_ack = (i == 0) || ($urandom_range(0, 3) == 0);
            tick();
            if (i == 0) chk("ignore_in_detect", 32'(bus.led_state), 32'd2);
        end
        bus.start_game = 1'b0;
        bus.result_ack = 1'b0;
        bus.color_done = 1'b1;
        bus.detected_color = make_det(mode);
        tick();
        bus.color_done = 1'b0;
        bus.detected_color = 8'($urandom);
        k = 1;
        while (!bus.result_valid && k < 40) begin
            tick();
            k++;
        end
        chk("cd_to_rv", 32'(k), 32'd2);
        r = bus.result;
        for (int i = 0; i < ack_delay; i++) begin
            bus.color_done = ($urandom_range(0, 2) == 0);
            tick();
            chk("rv_held", 32'(bus.result_valid), 32'd1);
        end
        bus.color_done = 1'b0;
        bus.result_ack = 1'b1;
        tick();
        bus.result_ack = 1'b0;
        chk("rv_drop", 32'(bus.result_valid), 32'd0);
        if (!last) begin
            wait_req(k);
            chk("ack_to_req", 32'(k + 1), 32'd3);
        end else begin
            tick();
            chk("game_over_after_ack", 32'(bus.game_over), 32'd1);
        end
    endtask

    initial begin
        logic [1:0] r;
        int n;
        bus.start_game = 1'b0;
        bus.lvl = 2'd0;
        bus.color_done = 1'b0;
        bus.detected_color = 8'd0;
        bus.result_ack = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_busy",  32'(bus.busy),      32'd0);
        chk("rst_led",   32'(bus.led_state), 32'd0);
        chk("rst_score", 32'(bus.score),     32'd0);
        chk("rst_qv",    32'(bus.q_valid),   32'd0);
        #2 rst_n = 1'b1;
        repeat (2) tick();

        // two rounds at lvl 3: match then mismatch
        start_game(2'd3);
        play_round(0, 3, 4, 1'b0, r);
        chk("g1_r0_result", 32'(r), 32'd1);
        chk("g1_r0_score", 32'(bus.score), 32'd1);
        play_round(1, 2, 1, 1'b1, r);
        chk("g1_r1_result", 32'(r), 32'd2);
        chk("g1_score", 32'(bus.score), 32'd1);
        chk("g1_round_idx", 32'(bus.round_idx), 32'd1);

        // lvl 0: only slot 0 compared, upper question slots zero
        repeat (3) tick();
        start_game(2'd0);
        chk("restart_score_clear", 32'(bus.score), 32'd0);
        chk("lvl0_q_upper", 32'(bus.question[7:2]), 32'd0);
        play_round(3, 2, 0, 1'b0, r);
        chk("lvl0_result", 32'(r), 32'd1);
        play_round(2, 1, 2, 1'b1, r);

`ifdef ROUND_TIMEOUT_EN
        // no color_done: forced timeout; then color_done exactly in the timeout cycle
        start_game(2'd3);
        n = 0;
        while (bus.led_state != 3'd3 && n < 40) begin
            tick();
            n++;
        end
        chk("timeout_to_compare", 32'(n), 32'd16);
        tick();
        chk("timeout_rv", 32'(bus.result_valid), 32'd1);
        chk("timeout_result", 32'(bus.result), 32'd3);
        chk("timeout_score", 32'(bus.score), 32'd0);
        bus.result_ack = 1'b1;
        tick();
        bus.result_ack = 1'b0;
        wait_req(n);
        chk("timeout_ack_to_req", 32'(n + 1), 32'd3);
        play_round(0, TO - 1, 0, 1'b1, r);
        chk("cd_wins_timeout", 32'(r), 32'd1);
`endif

        // reset asserted while a result is being reported
        repeat (2) tick();
        start_game(2'($urandom));
        bus.color_done = 1'b1;
        bus.detected_color = make_det(0);
        tick();
        bus.color_done = 1'b0;
        repeat (2) tick();
        chk("pre_reset_rv", 32'(bus.result_valid), 32'd1);
        chk("pre_reset_score", 32'(bus.score), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        chk("async_rst_rv", 32'(bus.result_valid), 32'd0);
        chk("async_rst_score", 32'(bus.score), 32'd0);
        chk("async_rst_question", 32'(bus.question), 32'd0);
        tick();
        chk("rst_led_idle", 32'(bus.led_state), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        start_game(2'd1);
        play_round(2, 2, 1, 1'b0, r);
        play_round(2, 0, 0, 1'b1, r);

        // randomized games
        for (int g = 0; g < 25; g++) begin
            repeat ($urandom_range(0, 3)) tick();
            start_game(2'($urandom));
            for (int rr = 0; rr < NR; rr++)
                play_round(2, $urandom_range(0, 10), $urandom_range(0, 4), rr == NR - 1, r);
        end

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/game_round_controller.md
# game_round_controller

Round sequencer for the color-matching game. It owns the color-comparison path for a whole game: it generates each round's question pattern and requests a color detection. It then compares the detected pattern against the question, masked by difficulty level, and reports each result to the GUI with a held valid/ack handshake. It also tracks the round index and score across a fixed number of rounds.

## Interface
Parameters:
- NUM_ROUNDS, 8, rounds per game (1..15)
- TIMEOUT_CYCLES, 25_000_000, detection timeout in pclk cycles (≥2)
- LFSR_SEED, 8'hA5, question LFSR reset value (must be nonzero)

Ports:
- pclk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start_game  in  1  pulse; starts a game from IDLE or DONE
- lvl  in  2  difficulty; compare slots 0..lvl; latched on start_game
- detect_req  out  1  one-cycle pulse requesting color detection
- color_done  in  1  detection complete; detected_color valid this cycle
- detected_color  in  8  four 2-bit colors; slot i = bits [2i+1:2i]
- question  out  8  current question; slots above lvl forced to 0
- q_valid  out  1  question valid (GEN_Q exit through REPORT)
- result  out  2  01 win, 10 lose, 11 timeout, 00 none
- result_valid  out  1  result held for GUI
- result_ack  in  1  GUI consumed result
- score  out  4  wins this game, saturating at 15
- round_idx  out  4  zero-based current round
- busy  out  1  high in every state except IDLE and DONE
- game_over  out  1  high in DONE
- led_state  out  3  debug: current state encoding

## Operation
- States: IDLE=0, GEN_Q=1, DETECT=2, COMPARE=3, REPORT=4, NEXT=5, DONE=6.
- IDLE/DONE → GEN_Q on start_game. The transition clears score, round_idx and result, and latches lvl. start_game is ignored in all other states.
- LFSR: 8-bit Galois, mask 8'hB8, shifts every cycle from reset. In GEN_Q, question ← lfsr with slots above lvl zeroed. GEN_Q → DETECT.
- DETECT:
  - detect_req pulses on the first DETECT cycle only.
  - On color_done, the block captures detected_color and moves to COMPARE.
- COMPARE, one cycle:
  - match = all slots 0..lvl equal. Slots above lvl are ignored.
  - On a match, result=01 and score+1, saturating.
  - Otherwise result=10.
  - A timeout entry sets result=11 with no score change.
  - COMPARE → REPORT.
- REPORT: result_valid=1 and result is held. On result_ack → NEXT.
- NEXT:
  - If round_idx==NUM_ROUNDS-1 → DONE.
  - Otherwise round_idx+1 and → GEN_Q.
- DONE: game_over=1. score and the last result are held.
- color_done outside DETECT is ignored. result_ack outside REPORT is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, lfsr=LFSR_SEED.
- reset_n low mid-game aborts immediately and returns every output to its reset value.
- Fixed cycle counts:
  - start_game to detect_req: 2 cycles (GEN_Q, then DETECT with the pulse).
  - color_done to result_valid rising: 2 cycles.
- result_valid drops the cycle after result_ack is sampled high. The next detect_req follows 3 cycles after the ack (NEXT, GEN_Q, DETECT).
- q_valid goes high the cycle after GEN_Q and stays high through REPORT. It drops in NEXT.
- score updates the cycle after COMPARE, together with result.

## Configuration
- ROUND_TIMEOUT_EN defined:
  - A 25-bit counter clears on DETECT entry and increments each DETECT cycle.
  - When the counter reaches TIMEOUT_CYCLES-1 without color_done, the block goes to COMPARE with a forced timeout (result 11).
  - If color_done and the timeout coincide, color_done wins.
- ROUND_TIMEOUT_EN undefined: no counter. DETECT waits indefinitely and result is never 11.

## Test plan
All scenarios use NUM_ROUNDS=2, TIMEOUT_CYCLES=16, LFSR_SEED=8'hA5.
- Reset, then start_game with lvl=3. Reply color_done with detected_color=question → detect_req 2 cycles after start, result=01, score=1, result_valid held until ack.
- lvl=0; detected_color matches slot 0 only, slots 1–3 wrong → result=01 and question[7:2]=0.
- Two rounds: first match, second mismatch → results 01 then 10, score=1, game_over=1 after the second ack, round_idx=1.
- ROUND_TIMEOUT_EN defined, no color_done → result=11 sixteen cycles after DETECT entry, score unchanged. With color_done in the timeout cycle → result 01 or 10, not 11.
- start_game pulsed in DETECT, plus color_done and result_ack pulsed in the wrong states → all ignored; state and outputs unchanged.
- reset_n low during REPORT → all outputs 0 next edge, state IDLE; a new start_game runs normally.
